// File: rtl/multicast_scheduler.sv
// Central sequencer for a group of multicast tag-match receivers on one broadcast bus.
// Programs receiver tags in CONFIG, then issues buffered packets once every matching receiver is ready.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_CONFIG | program receiver tags, keep shadow table, no packet intake
//   ST_RUN    | accept packets into FIFO, issue or drop the head
//   ST_DRAIN  | no intake, keep issuing/dropping until FIFO is empty
module multicast_scheduler #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int BITWIDTH      = 16,
  parameter int NUM_UNITS     = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int UNIT_IDX_W    = $clog2(NUM_UNITS)
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     cfg_valid,
  input  logic [UNIT_IDX_W-1:0]    cfg_unit,
  input  logic [ADDRESS_WIDTH-1:0] cfg_tag,
  input  logic                     cfg_start,
  input  logic                     cfg_stop,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] in_tag,
  input  logic [BITWIDTH-1:0]      in_data,
  input  logic [NUM_UNITS-1:0]     unit_ready,
  output logic [NUM_UNITS-1:0]     program_out,
  output logic [ADDRESS_WIDTH-1:0] tag_id_out,
  output logic                     bus_enable,
  output logic [ADDRESS_WIDTH-1:0] bus_tag,
  output logic [BITWIDTH-1:0]      bus_data,
  output logic                     drop_pulse,
  output logic [1:0]               mode
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [NUM_UNITS-1:0] UNIT_ONE = NUM_UNITS'(1);

  typedef enum logic [1:0] {
    ST_CONFIG = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
  logic [ADDRESS_WIDTH-1:0] shadow_q [NUM_UNITS];
  logic [ADDRESS_WIDTH-1:0] shadow_d [NUM_UNITS];
  logic [NUM_UNITS-1:0]     program_q, program_d;
  logic [ADDRESS_WIDTH-1:0] tag_id_q, tag_id_d;
  logic                     bus_en_q, bus_en_d;
  logic [ADDRESS_WIDTH-1:0] bus_tag_q, bus_tag_d;
  logic [BITWIDTH-1:0]      bus_data_q, bus_data_d;
  logic                     drop_q, drop_d;
  logic                     in_ready_q, in_ready_d;

  logic [ADDRESS_WIDTH-1:0] mem_tag  [FIFO_DEPTH];
  logic [BITWIDTH-1:0]      mem_data [FIFO_DEPTH];

  logic                     empty, full, push, pop;
  logic [ADDRESS_WIDTH-1:0] head_tag;
  logic [BITWIDTH-1:0]      head_data;
  logic [NUM_UNITS-1:0]     mask;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    head_tag  = mem_tag[rd_ptr_q[IDX_W-1:0]];
    head_data = mem_data[rd_ptr_q[IDX_W-1:0]];
    mask      = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      mask[i] = (shadow_q[i] == head_tag);
    end

    state_d   = state_q;
    shadow_d  = shadow_q;
    program_d = '0;
    tag_id_d  = '0;
    push      = 1'b0;

    case (state_q)
      ST_CONFIG: begin
        if (cfg_valid && (32'(cfg_unit) < NUM_UNITS)) begin
          shadow_d[cfg_unit] = cfg_tag;
          program_d          = UNIT_ONE << cfg_unit;
          tag_id_d           = cfg_tag;
        end
        if (cfg_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        push = in_valid && in_ready_q && !full;
        if (cfg_stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (empty) state_d = ST_CONFIG;
      end
      default: state_d = ST_CONFIG;
    endcase

    // An unmatched head is discarded; a matched head waits for all its receivers.
    pop = (state_q != ST_CONFIG) && !empty &&
          ((mask == '0) || ((mask & ~unit_ready) == '0));

    drop_d     = pop && (mask == '0);
    bus_en_d   = pop && (mask != '0);
    bus_tag_d  = bus_en_d ? head_tag  : bus_tag_q;
    bus_data_d = bus_en_d ? head_data : bus_data_q;

    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = wr_ptr_d - rd_ptr_d;
    in_ready_d = (state_d == ST_RUN) && (count_d != PTR_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_CONFIG;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < NUM_UNITS; i++) shadow_q[i] <= '0;
      program_q  <= '0;
      tag_id_q   <= '0;
      bus_en_q   <= 1'b0;
      bus_tag_q  <= '0;
      bus_data_q <= '0;
      drop_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shadow_q   <= shadow_d;
      program_q  <= program_d;
      tag_id_q   <= tag_id_d;
      bus_en_q   <= bus_en_d;
      bus_tag_q  <= bus_tag_d;
      bus_data_q <= bus_data_d;
      drop_q     <= drop_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_tag[wr_ptr_q[IDX_W-1:0]]  <= in_tag;
      mem_data[wr_ptr_q[IDX_W-1:0]] <= in_data;
    end
  end

  assign in_ready    = in_ready_q;
  assign program_out = program_q;
  assign tag_id_out  = tag_id_q;
  assign bus_enable  = bus_en_q;
  assign bus_tag     = bus_tag_q;
  assign bus_data    = bus_data_q;
  assign drop_pulse  = drop_q;
  assign mode        = state_q;

endmodule

// File: tb/tb_multicast_scheduler.sv
// Directed bench for multicast_scheduler: tag programming, issue/drop ordering,
// FIFO full, drain sequencing and reset while packets are queued.
module tb_multicast_scheduler;

  logic        clk = 1'b0;
  logic        rstb;
  logic        cfg_valid, cfg_start, cfg_stop, in_valid;
  logic [1:0]  cfg_unit;
  logic [3:0]  cfg_tag, in_tag, unit_ready;
  logic [15:0] in_data;
  logic        in_ready, bus_enable, drop_pulse;
  logic [3:0]  program_out, tag_id_out, bus_tag;
  logic [15:0] bus_data;
  logic [1:0]  mode;

  int checks = 0;
  int errors = 0;

  multicast_scheduler dut (
    .clk(clk), .rstb(rstb),
    .cfg_valid(cfg_valid), .cfg_unit(cfg_unit), .cfg_tag(cfg_tag),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
    .unit_ready(unit_ready), .program_out(program_out), .tag_id_out(tag_id_out),
    .bus_enable(bus_enable), .bus_tag(bus_tag), .bus_data(bus_data),
    .drop_pulse(drop_pulse), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_chk(input string tag, input logic [3:0] t, input logic [15:0] d);
    chk({tag, "_en"}, 32'(bus_enable), 32'd1);
    chk({tag, "_tag"}, 32'(bus_tag), 32'(t));
    chk({tag, "_data"}, 32'(bus_data), 32'(d));
  endtask

  initial begin
    logic [3:0]  cfg_tags [4];
    logic [3:0]  fill_tags [4];
    cfg_tags  = '{4'd3, 4'd5, 4'd5, 4'd9};
    fill_tags = '{4'd5, 4'd9, 4'd3, 4'd5};

    rstb = 1'b1; cfg_valid = 0; cfg_unit = 0; cfg_tag = 0; cfg_start = 0; cfg_stop = 0;
    in_valid = 0; in_tag = 0; in_data = 0; unit_ready = 4'h0;
    #1 rstb = 1'b0;
    #2;
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_program", 32'(program_out), 32'd0);
    chk("rst_tag_id", 32'(tag_id_out), 32'd0);
    chk("rst_bus_en", 32'(bus_enable), 32'd0);
    chk("rst_bus_tag", 32'(bus_tag), 32'd0);
    chk("rst_bus_data", 32'(bus_data), 32'd0);
    chk("rst_drop", 32'(drop_pulse), 32'd0);
    #9 rstb = 1'b1;

    // configure units 0..3 with tags 3,5,5,9
    cfg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_unit = 2'(i);
      cfg_tag  = cfg_tags[i];
      step();
      chk("cfg_program", 32'(program_out), 32'(4'b0001 << i));
      chk("cfg_tag_id", 32'(tag_id_out), 32'(cfg_tags[i]));
      chk("cfg_in_ready", 32'(in_ready), 32'd0);
    end
    cfg_valid = 1'b0;
    step();
    chk("cfg_strobe_end", 32'(program_out), 32'd0);

    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("run_mode", 32'(mode), 32'd1);
    chk("run_in_ready", 32'(in_ready), 32'd1);

    // cfg_valid is ignored in RUN: no strobe, and unit 1 keeps tag 5
    cfg_valid = 1'b1; cfg_unit = 2'd1; cfg_tag = 4'hF;
    step();
    cfg_valid = 1'b0;
    chk("run_cfg_ignored", 32'(program_out), 32'd0);

    // single packet, all ready: 2-cycle latency
    unit_ready = 4'hF;
    in_valid = 1'b1; in_tag = 4'd5; in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    chk("lat_not_early", 32'(bus_enable), 32'd0);
    step();
    issue_chk("beef", 4'd5, 16'hBEEF);
    step();
    chk("beef_pulse_end", 32'(bus_enable), 32'd0);
    chk("beef_data_hold", 32'(bus_data), 32'hBEEF);

    // unit 2 busy blocks tag 5; tag 3 behind it must wait
    unit_ready = 4'b1011;
    in_valid = 1'b1; in_tag = 4'd5; in_data = 16'h1111;
    step();
    in_tag = 4'd3; in_data = 16'h3333;
    step();
    in_valid = 1'b0;
    chk("busy_wait0", 32'(bus_enable), 32'd0);
    step();
    chk("busy_wait1", 32'(bus_enable), 32'd0);
    unit_ready = 4'hF;
    step();
    issue_chk("busy_rel", 4'd5, 16'h1111);
    step();
    issue_chk("order_next", 4'd3, 16'h3333);
    step();
    chk("order_idle", 32'(bus_enable), 32'd0);

    // unmatched tag is dropped
    in_valid = 1'b1; in_tag = 4'd7; in_data = 16'h7777;
    step();
    in_valid = 1'b0;
    step();
    chk("drop_pulse", 32'(drop_pulse), 32'd1);
    chk("drop_no_bus", 32'(bus_enable), 32'd0);
    chk("drop_tag_hold", 32'(bus_tag), 32'd3);
    step();
    chk("drop_pulse_end", 32'(drop_pulse), 32'd0);

    // fill FIFO with everyone busy, then release
    unit_ready = 4'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_tag  = fill_tags[i];
      in_data = 16'hA0 + 16'(i);
      step();
      chk("fill_in_ready", 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    step();
    chk("full_hold", 32'(in_ready), 32'd0);
    chk("full_no_bus", 32'(bus_enable), 32'd0);
    unit_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      issue_chk("fill_issue", fill_tags[i], 16'hA0 + 16'(i));
      chk("fill_in_ready_back", 32'(in_ready), 32'd1);
    end
    step();
    chk("fill_idle", 32'(bus_enable), 32'd0);

    // drain with 2 packets queued
    unit_ready = 4'h0;
    in_valid = 1'b1; in_tag = 4'd5; in_data = 16'hC0;
    step();
    in_tag = 4'd9; in_data = 16'hC1;
    step();
    in_valid = 1'b0;
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    chk("drain_mode", 32'(mode), 32'd2);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    unit_ready = 4'hF;
    step();
    issue_chk("drain_c0", 4'd5, 16'hC0);
    chk("drain_mode_c0", 32'(mode), 32'd2);
    step();
    issue_chk("drain_c1", 4'd9, 16'hC1);
    chk("drain_mode_c1", 32'(mode), 32'd2);
    step();
    chk("drain_done_mode", 32'(mode), 32'd0);
    chk("drain_done_bus", 32'(bus_enable), 32'd0);

    // drain entered empty lasts one cycle
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("empty_run_mode", 32'(mode), 32'd1);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    chk("empty_drain_mode", 32'(mode), 32'd2);
    step();
    chk("empty_drain_exit", 32'(mode), 32'd0);

    // reset with packets queued
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    unit_ready = 4'h0;
    in_valid = 1'b1; in_tag = 4'd5; in_data = 16'hD0;
    step();
    in_data = 16'hD1;
    step();
    in_valid = 1'b0;
    #2 rstb = 1'b0;
    #1;
    chk("midrst_mode", 32'(mode), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_bus_en", 32'(bus_enable), 32'd0);
    #3 rstb = 1'b1;
    unit_ready = 4'hF;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("postrst_mode", 32'(mode), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("postrst_no_bus", 32'(bus_enable), 32'd0);
      chk("postrst_no_drop", 32'(drop_pulse), 32'd0);
    end

    // shadow table cleared to 0: tag 0 matches every unit, tag 5 matches none
    in_valid = 1'b1; in_tag = 4'd0; in_data = 16'h0E0E;
    step();
    in_tag = 4'd5; in_data = 16'h5555;
    step();
    in_valid = 1'b0;
    issue_chk("shadow_clr_tag0", 4'd0, 16'h0E0E);
    step();
    chk("shadow_clr_drop", 32'(drop_pulse), 32'd1);
    chk("shadow_clr_nobus", 32'(bus_enable), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicast_scheduler.md
Name: multicast_scheduler

Overview:
- Central sequencer for a group of NUM_UNITS multicast tag-match receivers sharing one broadcast bus.
- CONFIG mode: programs each receiver's tag ID through one-hot program strobes and keeps a shadow copy of all tags.
- RUN mode: buffers tagged packets in a FIFO and issues each one onto the bus only when every receiver whose tag matches reports ready.
- Drops packets that match no receiver.

Parameters:
- ADDRESS_WIDTH, 4, tag width.
- BITWIDTH, 16, data width.
- NUM_UNITS, 4, number of receivers; must be at least 2.
- FIFO_DEPTH, 4, packet FIFO entries; must be a power of 2.
- UNIT_IDX_W, clog2(NUM_UNITS), width of the unit index.

Ports:
- clk  in  1  clock.
- rstb  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  write request; the tag_id for unit cfg_unit is cfg_tag.
- cfg_unit  in  UNIT_IDX_W  target unit index.
- cfg_tag  in  ADDRESS_WIDTH  tag value to program.
- cfg_start  in  1  leave CONFIG and enter RUN.
- cfg_stop  in  1  leave RUN and enter DRAIN.
- in_valid  in  1  packet valid.
- in_ready  out  1  packet accepted when in_valid and in_ready are both high.
- in_tag  in  ADDRESS_WIDTH  packet destination tag.
- in_data  in  BITWIDTH  packet payload.
- unit_ready  in  NUM_UNITS  per-receiver ready.
- program  out  NUM_UNITS  one-hot program strobe.
- tag_id_out  out  ADDRESS_WIDTH  tag value presented with program.
- bus_enable  out  1  broadcast valid.
- bus_tag  out  ADDRESS_WIDTH  broadcast tag.
- bus_data  out  BITWIDTH  broadcast payload.
- drop_pulse  out  1  one-cycle pulse for each packet dropped with no matching unit.
- mode  out  2  current state: 0=CONFIG, 1=RUN, 2=DRAIN.

Behaviour:
- Reset (asynchronous):
  - State goes to CONFIG; FIFO empties.
  - Shadow tag table is cleared to 0.
  - All outputs go to 0: program, tag_id_out, bus_enable, bus_tag, bus_data, drop_pulse, in_ready, mode=0.
  - Reset asserted mid-packet discards the FIFO contents with no issue.
- All outputs are registered.
- CONFIG:
  - cfg_valid at edge k: shadow[cfg_unit] <= cfg_tag.
  - In the cycle after edge k: program has only bit cfg_unit set, and tag_id_out=cfg_tag; both last exactly 1 cycle.
  - Back-to-back cfg_valid produces back-to-back strobes.
  - cfg_unit >= NUM_UNITS is ignored: no strobe, no table write.
  - in_ready=0.
  - cfg_start moves to RUN at the next edge. If cfg_valid is in the same cycle, the write is still performed.
  - cfg_stop is ignored.
- RUN:
  - in_ready = FIFO not full. There is no pass-through when full: a push while full is impossible, because in_ready is low.
  - Head match mask: bit i set when shadow[i]==head_tag.
  - mask==0:
    - Head is popped at the next edge and drop_pulse is high for 1 cycle after that edge.
    - Nothing is issued on the bus.
  - mask!=0 and (mask & ~unit_ready)==0:
    - Head is popped at the next edge.
    - bus_enable=1 for exactly 1 cycle after that edge, with bus_tag and bus_data equal to the head's tag and data.
  - Otherwise the head waits; there is no reordering and no timeout.
  - At most one pop per cycle. Push and pop can occur in the same cycle; the count is unchanged.
  - Minimum latency: packet accepted at edge k gives bus_enable high in the cycle after edge k+1, i.e. 2 cycles.
  - bus_tag and bus_data hold their last values when bus_enable=0.
  - cfg_valid is ignored.
  - cfg_stop moves to DRAIN.
- DRAIN:
  - in_ready=0; issue and drop rules continue.
  - When the FIFO is empty and no pop is pending, return to CONFIG at the next edge.
  - If the FIFO is empty on entry, DRAIN lasts 1 cycle.
  - cfg_start and cfg_valid are ignored.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, using the wrap bit to distinguish full from empty, and wrap naturally.

Test Plan:
- Reset then configure units 0..3 with tags 3,5,5,9 → program = 0001,0010,0100,1000 on successive cycles; tag_id_out = 3,5,5,9; in_ready=0 throughout.
- cfg_start; send tag=5 data=0xBEEF with unit_ready=1111 → bus_enable pulse 2 cycles after acceptance, bus_tag=5, bus_data=0xBEEF.
- Send tag=5 with unit_ready=1011 (unit 2 busy) → no issue. Raise unit_ready[2] → issue on the following cycle. A subsequent tag=3 packet is not issued before it.
- Send tag=7 (no match) → drop_pulse for 1 cycle, no bus_enable, FIFO count decremented.
- unit_ready=0000 and push 4 packets → in_ready=0 after the 4th. Set unit_ready=1111 → packets issue in order on 4 consecutive cycles and in_ready returns to 1.
- cfg_stop with 2 packets queued → mode=2, in_ready=0, both packets issue, then mode=0. Also: assert rstb low mid-queue → FIFO empties, no bus_enable, mode=0.
